// File: rtl/mod14_down_counter.sv
// rtl/mod14_down_counter.sv - modulo-MOD down counter with load, enable, terminal count and cascade borrow
// Optional sticky borrow flag: define MODDN_STICKY_BORROW_EN to add clr_flag / borrow_flag.
module mod14_down_counter #(
    parameter int MOD   = 14,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             borrow
`ifdef MODDN_STICKY_BORROW_EN
    ,
    input  logic             clr_flag,
    output logic             borrow_flag
`endif
);

    // Top count value and the modulus widened by one bit so MOD == 2**WIDTH is representable.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

    // Reject a modulus the counter cannot represent or that makes no sense.
    if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_mod_check
        $fatal(1, "mod14_down_counter: MOD out of range 2 .. 2**WIDTH");
    end

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             d_in_range;
    logic             q_in_range;

    // Range tests; both are constant-true when MOD == 2**WIDTH, leaving clamp/self-correct inert.
    always_comb begin
        d_in_range = ({1'b0, d} < MOD_EXT);
        q_in_range = ({1'b0, q_q} < MOD_EXT);
    end

    // Next count: load (clamped) beats enable; decrement wraps 0 -> MAX and repairs illegal states.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d_in_range ? d : MAX_VAL;
        end else if (en) begin
            if (q_q == '0 || !q_in_range) begin
                q_d = MAX_VAL;
            end else begin
                q_d = q_q - 1'b1;
            end
        end
    end

    // Count register; synchronous reset reloads the top value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= MAX_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    // Zero-latency status: tc on zero, borrow only when a real wrap will happen this edge.
    always_comb begin
        q      = q_q;
        tc     = (q_q == '0);
        borrow = en & ~load & (q_q == '0);
    end

`ifdef MODDN_STICKY_BORROW_EN
    logic flag_q;
    logic flag_d;

    // Sticky flag: a borrow sets it and wins over a coincident clear.
    always_comb begin
        flag_d = flag_q;
        if (clr_flag) begin
            flag_d = 1'b0;
        end
        if (borrow) begin
            flag_d = 1'b1;
        end
    end

    // Flag register; reset overrides set and clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    // Drive the registered flag out.
    always_comb begin
        borrow_flag = flag_q;
    end
`endif

endmodule

// File: tb/tb_mod14_down_counter.sv
// tb/tb_mod14_down_counter.sv - scoreboard bench for mod14_down_counter and a two-stage cascade
module tb_mod14_down_counter;

    logic       clk = 1'b0;
    logic       rst_n, en, load, clr;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc, borrow, flag;

    logic       c_rst_n, c_en;
    logic [3:0] c0_q, c1_q;
    logic       c0_tc, c1_tc, c0_borrow, c1_borrow;
    logic       c0_flag, c1_flag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         sel;
        string      name;
        logic [3:0] q0;
        logic       tc;
        logic       borrow;
        logic [3:0] q1;
        logic       chkf;
        logic       flag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mod14_down_counter dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .d(d),
        .q(q), .tc(tc), .borrow(borrow)
`ifdef MODDN_STICKY_BORROW_EN
        , .clr_flag(clr), .borrow_flag(flag)
`endif
    );

    mod14_down_counter c0 (
        .clk(clk), .rst_n(c_rst_n), .en(c_en), .load(1'b0), .d(4'd0),
        .q(c0_q), .tc(c0_tc), .borrow(c0_borrow)
`ifdef MODDN_STICKY_BORROW_EN
        , .clr_flag(1'b0), .borrow_flag(c0_flag)
`endif
    );

    mod14_down_counter c1 (
        .clk(clk), .rst_n(c_rst_n), .en(c0_borrow), .load(1'b0), .d(4'd0),
        .q(c1_q), .tc(c1_tc), .borrow(c1_borrow)
`ifdef MODDN_STICKY_BORROW_EN
        , .clr_flag(1'b0), .borrow_flag(c1_flag)
`endif
    );

`ifndef MODDN_STICKY_BORROW_EN
    assign flag    = 1'b0;
    assign c0_flag = 1'b0;
    assign c1_flag = 1'b0;
`endif

    // Monitor: every cycle with a pending expectation, compare the DUT on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.sel == 0) begin
                if ({q, tc, borrow} !== {e.q0, e.tc, e.borrow}) begin
                    errors++;
                    $display("FAIL %s: got q=%0d tc=%b borrow=%b, expected q=%0d tc=%b borrow=%b",
                             e.name, q, tc, borrow, e.q0, e.tc, e.borrow);
                end
`ifdef MODDN_STICKY_BORROW_EN
                if (e.chkf) begin
                    checks++;
                    if (flag !== e.flag) begin
                        errors++;
                        $display("FAIL %s_flag: got borrow_flag=%b, expected %b", e.name, flag, e.flag);
                    end
                end
`endif
            end else begin
                if ({c0_q, c1_q, c1_borrow} !== {e.q0, e.q1, e.borrow}) begin
                    errors++;
                    $display("FAIL %s: got q0=%0d q1=%0d borrow1=%b, expected q0=%0d q1=%0d borrow1=%b",
                             e.name, c0_q, c1_q, c1_borrow, e.q0, e.q1, e.borrow);
                end
            end
        end
    end

    // Apply one cycle of inputs, optionally queue the expected observation, then advance one edge.
    task automatic vec(input logic r, input logic e_in, input logic l, input logic [3:0] dv,
                       input logic c, input logic chk, input logic [3:0] eq, input logic et,
                       input logic eb, input logic chkf, input logic ef, input string nm);
        exp_t x;
        rst_n = r; en = e_in; load = l; d = dv; clr = c;
        if (chk) begin
            x.sel = 0; x.name = nm; x.q0 = eq; x.tc = et; x.borrow = eb;
            x.q1 = 4'd0; x.chkf = chkf; x.flag = ef;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        c_rst_n = 1'b0; c_en = 1'b0;
        // Reset held two edges with en high; q is unknown before the first edge.
        vec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "pre_reset");
        vec(0, 1, 0, 0, 0, 1, 13, 0, 0, 0, 0, "reset_hold");
        vec(1, 1, 0, 0, 0, 1, 13, 0, 0, 0, 0, "release_13");
        vec(1, 1, 0, 0, 0, 1, 12, 0, 0, 0, 0, "count_12");
        vec(1, 0, 1, 13, 0, 1, 11, 0, 0, 0, 0, "count_11");
        // Full cycle 13..0 with a single borrow at zero.
        for (int i = 0; i < 14; i++) begin
            vec(1, 1, 0, 0, 0, 1, 4'(13 - i), (i == 13), (i == 13), 0, 0, $sformatf("cycle_%0d", i));
        end
        vec(1, 0, 0, 0, 0, 1, 13, 0, 0, 0, 0, "wrap_to_13");
        vec(1, 0, 1, 5, 0, 1, 13, 0, 0, 0, 0, "pre_load5");
        vec(1, 1, 1, 15, 0, 1, 5, 0, 0, 0, 0, "loaded_5");
        vec(1, 0, 1, 0, 0, 1, 13, 0, 0, 0, 0, "clamp_15");
        vec(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, "zero_idle");
        vec(1, 1, 1, 9, 0, 1, 0, 1, 0, 0, 0, "load_en_zero");
        vec(1, 0, 1, 7, 0, 1, 9, 0, 0, 0, 0, "loaded_9");
        for (int i = 0; i < 3; i++) begin
            vec(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, $sformatf("hold7_%0d", i));
        end
        vec(1, 1, 0, 0, 0, 1, 7, 0, 0, 0, 0, "run_7");
        vec(1, 1, 0, 0, 0, 1, 6, 0, 0, 0, 0, "run_6");
        vec(1, 1, 0, 0, 0, 1, 5, 0, 0, 0, 0, "run_5");
        vec(1, 1, 0, 0, 0, 1, 4, 0, 0, 0, 0, "run_4");
        vec(0, 1, 0, 0, 0, 1, 3, 0, 0, 0, 0, "run_3_rst");
        vec(0, 0, 1, 2, 0, 1, 13, 0, 0, 0, 0, "mid_reset");
        vec(1, 0, 1, 1, 0, 1, 13, 0, 0, 0, 0, "reset_over_load");
        vec(1, 0, 1, 14, 0, 1, 1, 0, 0, 0, 0, "loaded_1");
        vec(1, 0, 0, 0, 0, 1, 13, 0, 0, 0, 0, "clamp_14");
        // Sticky borrow flag behaviour (flag compared only when the feature is built).
        vec(1, 0, 0, 0, 1, 1, 13, 0, 0, 0, 0, "flag_clear");
        vec(1, 0, 1, 0, 0, 1, 13, 0, 0, 1, 0, "flag_cleared");
        vec(1, 1, 0, 0, 0, 1, 0, 1, 1, 1, 0, "flag_wrap");
        vec(1, 0, 0, 0, 0, 1, 13, 0, 0, 1, 1, "flag_set");
        vec(1, 0, 0, 0, 0, 1, 13, 0, 0, 1, 1, "flag_persist");
        vec(1, 0, 0, 0, 1, 1, 13, 0, 0, 1, 1, "flag_clr_pulse");
        vec(1, 0, 0, 0, 0, 1, 13, 0, 0, 1, 0, "flag_after_clr");
        vec(1, 0, 1, 0, 0, 1, 13, 0, 0, 1, 0, "flag_load0");
        vec(1, 1, 0, 0, 1, 1, 0, 1, 1, 1, 0, "flag_set_clr");
        vec(1, 0, 0, 0, 0, 1, 13, 0, 0, 1, 1, "flag_set_wins");
        vec(0, 0, 0, 0, 0, 1, 13, 0, 0, 1, 1, "flag_rst");
        vec(1, 0, 0, 0, 0, 1, 13, 0, 0, 1, 0, "flag_rst_clr");

        // Cascade: stage 1 steps once per 14 clocks, full period 196 clocks.
        c_rst_n = 1'b0; c_en = 1'b1;
        @(posedge clk);
        #1;
        c_rst_n = 1'b1;
        for (int k = 0; k <= 196; k++) begin
            if (k == 0 || k == 13 || k == 14 || k == 27 || k == 28 || k == 195 || k == 196) begin
                exp_t x;
                x.sel = 1; x.name = $sformatf("cascade_%0d", k);
                x.q0 = 4'(13 - (k % 14));
                x.q1 = 4'(13 - ((k / 14) % 14));
                x.tc = 1'b0;
                x.borrow = (k == 195);
                x.chkf = 1'b0; x.flag = 1'b0;
                sb.push_back(x);
            end
            @(posedge clk);
            #1;
        end

        // Bounded drain of the scoreboard.
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod14_down_counter.md
Name: mod14_down_counter

Overview:
Synchronous modulo-N down counter, default N=14: counts 13,12,...,0 then wraps to 13. It is the down-counting companion to the mod-14 up counter.
- Adds parallel load, count enable, terminal-count detect and a cascadable borrow output.
- Used for countdown timers and for tracking the remaining count against an up-counting source.

Parameters:
- MOD, 14, modulus; legal range 2 .. 2**WIDTH.
- WIDTH, 4, counter width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
- en  input  1  count enable; decrements when high.
- load  input  1  parallel load strobe; has priority over en.
- d  input  WIDTH  parallel load value.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal count; combinational, high when q == 0.
- borrow  output  1  combinational, = en & ~load & (q == 0); cascade pulse into the next stage's en.

Behaviour:
- Single clock domain. All state updates on the rising edge of clk. No asynchronous paths.
- Priority per edge, highest first:
  - 1) rst_n == 0: q <= MOD-1. Reset is synchronous, so q holds its value until the first edge with rst_n low.
  - 2) load == 1: q <= d if d < MOD, else q <= MOD-1 (out-of-range load clamps).
  - 3) en == 1: q <= MOD-1 if q == 0, else q <= q-1.
  - 4) otherwise: q holds.
- Reset values: q = MOD-1 (13), so tc = 0. borrow is 0 after reset whatever the value of en.
- Latency:
  - load and count both take effect on the edge where they are sampled; new q is visible one cycle later.
  - tc and borrow have zero latency relative to q, en and load.
- Wrap: the 0 -> MOD-1 transition occurs only with en=1 and load=0. borrow is high during the cycle before that edge.
- Simultaneous load & en: load wins, no decrement, borrow = 0.
- Reset mid-count, or reset with load high: reset wins, q = MOD-1 on that edge.
- Arithmetic is modulo MOD, never modulo 2**WIDTH.
  - States MOD .. 2**WIDTH-1 are unreachable.
  - If such a state is ever present, the next en edge forces q <= MOD-1 (self-correcting). tc stays 0 in those states.
- When MOD == 2**WIDTH, the clamp and self-correction logic is inert.
- Elaboration check: a MOD outside its legal range is reported as a fatal error.

Optional Feature:
- Macro: MODDN_STICKY_BORROW_EN.
- When defined, the block adds:
  - input clr_flag (1 bit);
  - output borrow_flag (1 bit, registered).
- borrow_flag operation:
  - set on any edge where borrow == 1;
  - cleared on an edge with clr_flag == 1 or rst_n == 0;
  - if set and clear coincide, set wins (rst_n still overrides both);
  - reset value 0.
- When not defined: clr_flag and borrow_flag do not exist, and no extra flops are inferred.

Test Plan:
- Reset: rst_n=0 for 2 cycles with en=1 -> q=13, tc=0, borrow=0. Release rst_n -> next edges give 12, 11.
- Full cycle: en=1 for 14 cycles from 13 -> sequence 13..0, then 13. borrow=1 only while q=0, exactly once per 14 cycles.
- Load: load=1, d=5 -> q=5 next cycle. load=1, d=15 -> q=13 (clamp). load=1 with en=1 at q=0 -> q=d, borrow=0.
- Hold and mid-run reset: en=0 at q=7 for 3 cycles -> q stays 7. rst_n=0 at q=3 with en=1 -> q=13 on that edge.
- Cascade: two instances, stage-0 borrow drives stage-1 en, count from 13/13 -> stage 1 decrements once every 14 clocks. Total period 196 clocks.
- With MODDN_STICKY_BORROW_EN: wrap sets borrow_flag=1, which persists. clr_flag pulse clears it. clr_flag coinciding with borrow -> borrow_flag stays 1.
